// File: rtl/div_pkg.sv
// Shared encodings for the sequential divider.
package div_pkg;

  localparam logic [1:0] DIV_W  = 2'b00;
  localparam logic [1:0] MOD_W  = 2'b01;
  localparam logic [1:0] DIV_WU = 2'b10;
  localparam logic [1:0] MOD_WU = 2'b11;

  localparam int unsigned ITER = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

endpackage

// File: rtl/div_trial_sub.sv
// One restoring-division step: (WIDTH+1)-bit trial subtract of divisor from
// the shifted partial remainder.
module div_trial_sub #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH:0]   part_rem,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] diff,
  output logic             no_borrow
);

  logic [WIDTH:0] d_full;

  // The carry-out is rebuilt from the top bits: with divisor < 2^WIDTH, a
  // borrow occurs only when part_rem[WIDTH]=0 and the result wraps into
  // its top bit.
  always_comb begin
    d_full    = part_rem - {1'b0, divisor};
    diff      = d_full[WIDTH-1:0];
    no_borrow = part_rem[WIDTH] | ~d_full[WIDTH];
  end

endmodule

// File: rtl/div_seq.sv
// Multi-cycle radix-2 restoring divider for div.w/mod.w/div.wu/mod.wu.
module div_seq
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] src0,
  input  logic [WIDTH-1:0] src1,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] res
);

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH-1:0]   rem_q;
  logic [WIDTH-1:0]   quo_q;
  logic [WIDTH-1:0]   dvs_q;
  logic               q_neg;
  logic               r_neg;
  logic               dz;
  logic               sel_rem;

  logic               a_neg;
  logic               b_neg;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [WIDTH:0]     rem33;
  logic [WIDTH-1:0]   diff;
  logic               no_borrow;
  logic [WIDTH-1:0]   quotient;
  logic [WIDTH-1:0]   remainder;

  // Operand magnitudes at load, shifted remainder, and final sign fix-up.
  // On divide-by-zero every step subtracts nothing, so the remainder path
  // rebuilds the original dividend; only the quotient needs forcing.
  always_comb begin
    a_neg     = ~op[1] & src0[WIDTH-1];
    b_neg     = ~op[1] & src1[WIDTH-1];
    a_mag     = a_neg ? -src0 : src0;
    b_mag     = b_neg ? -src1 : src1;
    rem33     = {rem_q, quo_q[WIDTH-1]};
    quotient  = dz ? '1 : (q_neg ? -quo_q : quo_q);
    remainder = r_neg ? -rem_q : rem_q;
  end

  div_trial_sub #(.WIDTH(WIDTH)) u_trial (
    .part_rem  (rem33),
    .divisor   (dvs_q),
    .diff      (diff),
    .no_borrow (no_borrow)
  );

  // Control FSM with datapath registers and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      q_neg   <= 1'b0;
      r_neg   <= 1'b0;
      dz      <= 1'b0;
      sel_rem <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      res     <= '0;
    end else if (flush) begin
      state <= IDLE;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            rem_q   <= '0;
            quo_q   <= a_mag;
            dvs_q   <= b_mag;
            q_neg   <= a_neg ^ b_neg;
            r_neg   <= a_neg;
            dz      <= (src1 == '0);
            sel_rem <= op[0];
            cnt     <= '0;
            busy    <= 1'b1;
            state   <= CALC;
          end
        end
        CALC: begin
          rem_q <= no_borrow ? diff : rem33[WIDTH-1:0];
          quo_q <= {quo_q[WIDTH-2:0], no_borrow};
          if (cnt == CNT_W'(ITER - 1)) begin
            cnt   <= '0;
            state <= FIX;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        FIX: begin
          res   <= sel_rem ? remainder : quotient;
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule
